// File: rtl/lsu_pkg.sv
// Shared definitions for the MW-stage load/store unit: access-width codes,
// FSM state encoding and the latched descriptor of an in-flight access.
package lsu_pkg;

   // funct3 access-width/sign codes
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   // What the load formatter needs once the op has been accepted.
   typedef struct packed {
      logic       ld;
      logic [2:0] funct3;
      logic [1:0] lo;
   } lsu_op_t;

endpackage

// File: rtl/mw_lsu_if.sv
// Request/acknowledge data-memory bus between the LSU (master) and memory (slave).
interface mw_lsu_if;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_ack, mem_rdata
   );

endinterface

// File: rtl/lsu_align.sv
// Purely combinational lane logic: store strobes/replication, legality and
// alignment flags for the incoming op, and load extraction/extension for the
// op already in flight.
module lsu_align
   import lsu_pkg::*;
(
   input  logic        ld,
   input  logic        st,
   input  logic [2:0]  funct3,
   input  logic [1:0]  lo,
   input  logic [31:0] sdata,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   output logic        legal,
   output logic        aligned,
   input  logic [2:0]  rd_funct3,
   input  logic [1:0]  rd_lo,
   input  logic [31:0] rdata,
   output logic [31:0] ldata
);

   logic [31:0] rshift;
   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   // Legality, alignment and store lane formatting for the MW-stage op
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      legal   = 1'b0;
      aligned = 1'b1;
      be      = 4'hF;
      wdata   = sdata;

      // A simultaneous load and store is never legal.
      if (ld && !st)
         legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
      else if (st && !ld)
         legal = funct3 inside {F3_B, F3_H, F3_W};

      // funct3[1:0] encodes the size for every legal code.
      case (funct3[1:0])
         2'b00: begin
            aligned = 1'b1;
            be      = 4'b0001 << lo;
            wdata   = {4{sdata[7:0]}};
         end
         2'b01: begin
            aligned = !lo[0];
            be      = 4'b0011 << lo;
            wdata   = {2{sdata[15:0]}};
         end
         default: begin
            aligned = (lo == 2'b00);
            be      = 4'hF;
            wdata   = sdata;
         end
      endcase
   end

   // Lane select and sign/zero extension of the returned read word
   always_comb begin
      rshift = rdata >> {rd_lo, 3'b000};
      rbyte  = rshift[7:0];
      rhalf  = rd_lo[1] ? rdata[31:16] : rdata[15:0];
      case (rd_funct3)
         F3_B:    ldata = {{24{rbyte[7]}}, rbyte};
         F3_BU:   ldata = {24'h0, rbyte};
         F3_H:    ldata = {{16{rhalf[15]}}, rhalf};
         F3_HU:   ldata = {16'h0, rhalf};
         default: ldata = rdata;
      endcase
   end

endmodule

// File: rtl/mw_lsu.sv
// MW-stage load/store unit: accepts one op at a time, runs it on the
// variable-latency memory bus, stalls the MW register while the bus is busy,
// aborts with an error after TIMEOUT wait cycles, and returns formatted load data.
module mw_lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_MW,
   input  logic        st_MW,
   input  logic [2:0]  funct3_MW,
   input  logic [31:0] ALUResult_MW,
   input  logic [31:0] rdata2_MW,
   input  logic        flush,
   output logic        Stall_MW,
   mw_lsu_if.master    mem,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        misalign,
   output logic        lsu_err
);

   lsu_state_t  state, state_nx;
   logic [CNT_W-1:0] cnt;

   logic        op_valid;
   logic        legal, aligned;
   logic [3:0]  be_fmt;
   logic [31:0] wdata_fmt, ldata_fmt;
   logic        accept, timeout;

   lsu_op_t     op_q;
   logic        kill_q;
   logic        we_q;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  be_q;
   logic [31:0] load_data_q;
   logic        err_q, misalign_q;

   assign op_valid = ld_MW | st_MW;

   lsu_align u_align (
      .ld        (ld_MW),
      .st        (st_MW),
      .funct3    (funct3_MW),
      .lo        (ALUResult_MW[1:0]),
      .sdata     (rdata2_MW),
      .be        (be_fmt),
      .wdata     (wdata_fmt),
      .legal     (legal),
      .aligned   (aligned),
      .rd_funct3 (op_q.funct3),
      .rd_lo     (op_q.lo),
      .rdata     (mem.mem_rdata),
      .ldata     (ldata_fmt)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   // Next state, acceptance, timeout detection, stall and request
   always_comb begin
      state_nx      = state;
      accept        = 1'b0;
      timeout       = 1'b0;
      Stall_MW      = 1'b0;
      mem.mem_req   = 1'b0;
      case (state)
         IDLE: begin
            // rst gates acceptance so the stall drops the instant reset asserts.
            if (rst && op_valid && !flush && legal && aligned) begin
               accept   = 1'b1;
               Stall_MW = 1'b1;
               state_nx = WAIT;
            end
         end
         WAIT: begin
            mem.mem_req = 1'b1;
            Stall_MW    = 1'b1;
            if (mem.mem_ack) begin
               state_nx = DONE;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               // This is the TIMEOUT-th wait cycle without an ack.
               timeout  = 1'b1;
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Request latch, wait counter, load result and error/misalign pulses
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: these registers feed outputs directly, so they are reset to give defined outputs.
      if (!rst) begin
         op_q        <= '0;
         kill_q      <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         cnt         <= '0;
         load_data_q <= '0;
         err_q       <= 1'b0;
         misalign_q  <= 1'b0;
      end else begin
         err_q      <= 1'b0;
         misalign_q <= 1'b0;

         // Rejected ops in IDLE: illegal takes precedence over misaligned.
         if (state == IDLE && op_valid && !flush) begin
            if (!legal)        err_q      <= 1'b1;
            else if (!aligned) misalign_q <= 1'b1;
         end

         if (accept) begin
            op_q    <= '{ld: ld_MW, funct3: funct3_MW, lo: ALUResult_MW[1:0]};
            kill_q  <= 1'b0;
            we_q    <= st_MW;
            addr_q  <= {ALUResult_MW[31:2], 2'b00};
            wdata_q <= wdata_fmt;
            be_q    <= be_fmt;
            cnt     <= '0;
         end

         if (state == WAIT) begin
            cnt <= cnt + 1'b1;
            // The bus transaction still completes; only the result is dropped.
            if (flush) kill_q <= 1'b1;
            if (mem.mem_ack && op_q.ld) load_data_q <= ldata_fmt;
            if (timeout) begin
               load_data_q <= '0;
               err_q       <= 1'b1;
            end
         end
      end
   end

   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;
   assign mem.mem_be    = be_q;

   assign load_data  = load_data_q;
   assign load_valid = (state == DONE) && op_q.ld && !kill_q;
   assign misalign   = misalign_q;
   assign lsu_err    = err_q;

endmodule

// File: doc/mw_lsu.md
Name: mw_lsu

Overview:
- Load/store unit on the consumer side of the MW pipeline register. It takes address, store data and width from the MW stage.
- It drives a variable-latency req/ack data-memory bus and returns formatted load data to writeback.
- It generates the stall that holds the MW register while a bus transaction is outstanding.

Parameters:
- TIMEOUT, 16: maximum WAIT cycles without mem_ack before the access is aborted with an error.
- CNT_W, $clog2(TIMEOUT+1): width of the timeout counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low (asserted at 0).
- ld_MW  in  1  MW-stage instruction is a load.
- st_MW  in  1  MW-stage instruction is a store.
- funct3_MW  in  3  access width/sign.
- ALUResult_MW  in  32  byte address.
- rdata2_MW  in  32  store data.
- flush  in  1  kill the MW-stage op (trap/interrupt redirect).
- Stall_MW  out  1  hold the MW pipeline register.
- mem_req  out  1  bus request.
- mem_we  out  1  write enable.
- mem_addr  out  32  word address; {ALUResult_MW[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte strobes.
- mem_ack  in  1  bus completion.
- mem_rdata  in  32  read word, valid when mem_ack=1.
- load_data  out  32  extended load result.
- load_valid  out  1  load_data valid (1-cycle pulse).
- misalign  out  1  misaligned access pulse.
- lsu_err  out  1  illegal funct3 or bus timeout pulse.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counter 0.
- FSM states: IDLE, WAIT, DONE.
- IDLE, op accepted:
  - Accept condition: (ld_MW|st_MW) & !flush & legal funct3 & aligned.
  - Stall_MW=1 combinationally in the same cycle.
  - Latch mem_we, mem_addr, mem_wdata, mem_be and funct3/addr[1:0].
  - Next state WAIT.
- IDLE, illegal or misaligned op:
  - Illegal funct3: load {011,110,111}; store anything other than {000,001,010}. Result: lsu_err pulse next cycle.
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0. Result: misalign pulse next cycle.
  - In both cases: no request, no stall, stay IDLE.
- WAIT:
  - mem_req=1. mem_we/addr/wdata/be stay stable until mem_ack is sampled 1.
  - Stall_MW=1.
  - Counter increments each cycle.
  - On mem_ack: for a load, register the formatted load_data; next DONE. mem_req drops the cycle after ack.
  - If counter reaches TIMEOUT with no ack: drop mem_req, lsu_err pulse, load_data=0, next DONE.
- DONE:
  - Stall_MW=0, load_valid=1 for one cycle if the op was a load and not flushed.
  - No acceptance in DONE. Next state IDLE.
  - The MW register advances at the end of DONE, so the op is never re-issued.
- Minimum latency: op in cycle 0 (stall); req in cycle 1 with ack (stall); DONE in cycle 2. That is 2 stall cycles.
- flush:
  - In IDLE: blocks acceptance.
  - In WAIT: the transaction is not aborted (the bus must complete), but the eventual load_valid is suppressed.
  - flush has no effect on timeout handling.
- Store formatting:
  - SB: be=4'b0001<<a[1:0], wdata={4{d[7:0]}}.
  - SH: be=4'b0011<<a[1:0], wdata={2{d[15:0]}}.
  - SW: be=4'hF, wdata=d.
- Load formatting: select byte/half lane by a[1:0].
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: full word.
- ld_MW and st_MW both 1: treated as illegal (lsu_err), no request.
- Reset mid-WAIT: immediate return to IDLE with mem_req=0. The bus slave must tolerate a dropped request.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - FSM state enum lsu_state_t {IDLE, WAIT, DONE}.
- One combinational sub-module, lsu_align. It computes mem_be, mem_wdata and the aligned/legal flags from funct3/addr/data, and extracts/extends load data from mem_rdata. The FSM, counter and registers live in mw_lsu.

Test Plan:
- Basic LW: LW at addr 0x100, ack in the first req cycle, rdata 0xDEADBEEF. Expect: Stall_MW high for exactly 2 cycles; load_valid with load_data=0xDEADBEEF in cycle 2.
- Byte loads: LB addr 0x103, rdata 0x80123456. Expect load_data=0xFFFFFF80. Same access with LBU: expect 0x00000080.
- Half-word store with delayed ack: SH addr 0x202, data 0x0000ABCD, ack after 5 cycles. Expect: mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_addr=0x200, all held stable across 5 WAIT cycles; Stall_MW high 6 cycles; no load_valid.
- Misaligned/illegal: LW addr 0x101. Expect misalign pulse, mem_req never asserted, Stall_MW=0. Load with funct3=011: expect lsu_err pulse, no request.
- Timeout: LW with mem_ack held 0. Expect mem_req high for TIMEOUT=16 cycles, then lsu_err pulse, DONE, Stall_MW released.
- Flush and reset during WAIT: flush asserted during WAIT of an LH. Expect transaction completes on ack, load_valid stays 0. Separately, rst=0 mid-WAIT: mem_req=0 and Stall_MW=0 immediately, without waiting for a clock edge.
